// File: rtl/chess_key_conditioner_if.sv
// Key bundle between the raw pushbutton pins and the chess layout/cursor matrix.
// The raw inputs are active-low keys and an active-high lock switch. The outputs use the matrix convention.
interface chess_key_conditioner_if;
   logic       KeyLeftRaw;
   logic       KeyRightRaw;
   logic       KeyUpRaw;
   logic       KeyDownRaw;
   logic       LockSwitchRaw;
   logic       KeyLeft;
   logic       KeyRight;
   logic       KeyUp;
   logic       KeyDown;
   logic       LockSwitch;
   logic [1:0] ActiveKey;
   logic       Repeating;

   modport master (
      output KeyLeftRaw, KeyRightRaw, KeyUpRaw, KeyDownRaw, LockSwitchRaw,
      input  KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch, ActiveKey, Repeating
   );

   modport slave (
      input  KeyLeftRaw, KeyRightRaw, KeyUpRaw, KeyDownRaw, LockSwitchRaw,
      output KeyLeft, KeyRight, KeyUp, KeyDown, LockSwitch, ActiveKey, Repeating
   );
endinterface

// File: rtl/chess_key_conditioner.sv
// Synchronises and debounces the navigation keys and the lock switch.
// It turns a held key into one move pulse followed by auto-repeat pulses (0 = ON).
module chess_key_conditioner #(
   parameter int unsigned DEBOUNCE_TICKS = 2,
   parameter int unsigned REPEAT_DELAY   = 5,
   parameter int unsigned REPEAT_PERIOD  = 2,
   parameter int unsigned CNT_WIDTH      = 4
) (
   input logic                    OutClock,
   input logic                    resetApp,
   chess_key_conditioner_if.slave keys
);
   localparam int unsigned NUM_IN   = 5;
   localparam int unsigned NUM_KEYS = 4;
   localparam int unsigned LOCK_IDX = 4;

   localparam logic [NUM_IN-1:0]    REL_LEVEL = 5'b01111;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] DEB_MAX   = CNT_WIDTH'(DEBOUNCE_TICKS);
   localparam logic [CNT_WIDTH-1:0] DELAY_LD  = CNT_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] PERIOD_LD = CNT_WIDTH'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

   logic [NUM_IN-1:0]    raw;
   logic [NUM_IN-1:0]    sync1;
   logic [NUM_IN-1:0]    sync2;
   logic [NUM_IN-1:0]    stable;
   logic [CNT_WIDTH-1:0] deb_cnt [NUM_IN];
   logic [NUM_KEYS-1:0]  pressed;
   logic [1:0]           prio_key;

   state_t               state;
   logic [CNT_WIDTH-1:0] rpt_cnt;
   logic [NUM_KEYS-1:0]  key_out;
   logic [1:0]           active;
   logic                 repeating;
   logic                 lock_out;

   // Bits 0..3 are Left, Right, Up and Down, so a bit index is also the key code.
   assign raw = {keys.LockSwitchRaw, keys.KeyDownRaw, keys.KeyUpRaw,
                 keys.KeyRightRaw, keys.KeyLeftRaw};

   always_ff @(posedge OutClock or posedge resetApp) begin
      if (resetApp) begin
         sync1 <= REL_LEVEL;
         sync2 <= REL_LEVEL;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // The stable level flips only after the count of differing samples has reached DEBOUNCE_TICKS.
   always_ff @(posedge OutClock or posedge resetApp) begin
      if (resetApp) begin
         stable <= REL_LEVEL;
         for (int unsigned i = 0; i < NUM_IN; i++) deb_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sync2[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] >= DEB_MAX) begin
               stable[i]  <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   assign pressed = ~stable[NUM_KEYS-1:0];

   // Left has the highest priority, then Right, Up and Down.
   always_comb begin
      prio_key = 2'd0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (pressed[i]) prio_key = 2'(i);
      end
   end

   always_ff @(posedge OutClock or posedge resetApp) begin
      if (resetApp) begin
         state     <= IDLE;
         rpt_cnt   <= '0;
         key_out   <= '1;
         active    <= 2'd0;
         repeating <= 1'b0;
         lock_out  <= 1'b0;
      end else begin
         key_out  <= '1;
         lock_out <= stable[LOCK_IDX];
         case (state)
            IDLE: begin
               if (|pressed) begin
                  active    <= prio_key;
                  key_out   <= ~(4'b0001 << prio_key);
                  rpt_cnt   <= DELAY_LD;
                  repeating <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD, REPEAT: begin
               if (!pressed[active]) begin
                  repeating <= 1'b0;
                  state     <= IDLE;
               end else if (rpt_cnt == '0) begin
                  key_out <= ~(4'b0001 << active);
                  rpt_cnt <= PERIOD_LD;
                  state   <= REPEAT;
               end else begin
                  rpt_cnt <= rpt_cnt - CNT_ONE;
               end
            end
            default: begin
               repeating <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign keys.KeyLeft    = key_out[0];
   assign keys.KeyRight   = key_out[1];
   assign keys.KeyUp      = key_out[2];
   assign keys.KeyDown    = key_out[3];
   assign keys.LockSwitch = lock_out;
   assign keys.ActiveKey  = active;
   assign keys.Repeating  = repeating;
endmodule

// File: tb/tb_chess_key_conditioner.sv
// Directed per-cycle vectors for chess_key_conditioner.
// The raw inputs change on the falling edge, and the outputs are compared on the next falling edge.
module tb_chess_key_conditioner;
   logic OutClock = 1'b0;
   logic resetApp;

   chess_key_conditioner_if bus ();

   chess_key_conditioner dut (
      .OutClock (OutClock),
      .resetApp (resetApp),
      .keys     (bus)
   );

   always #5 OutClock = ~OutClock;

   // raw = {lock, down, up, right, left}; keys = {Down, Up, Right, Left}
   typedef struct {
      int unsigned n;
      logic [4:0]  raw;
      logic [3:0]  keys;
      logic        lock;
      logic [1:0]  act;
      logic        rep;
   } vec_t;

   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;

   function automatic void add(input int unsigned n, input logic [4:0] raw, input logic [3:0] k,
                               input logic l, input logic [1:0] a, input logic r);
      vec_t v;
      v.n = n; v.raw = raw; v.keys = k; v.lock = l; v.act = a; v.rep = r;
      tbl.push_back(v);
   endfunction

   function automatic logic [7:0] outs();
      return {bus.KeyDown, bus.KeyUp, bus.KeyRight, bus.KeyLeft,
              bus.LockSwitch, bus.ActiveKey, bus.Repeating};
   endfunction

   task automatic drive(input logic [4:0] raw);
      bus.LockSwitchRaw = raw[4];
      bus.KeyDownRaw    = raw[3];
      bus.KeyUpRaw      = raw[2];
      bus.KeyRightRaw   = raw[1];
      bus.KeyLeftRaw    = raw[0];
   endtask

   task automatic check(input string name, input logic [7:0] exp);
      logic [7:0] got;
      got = outs();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got keys=%b lock=%b act=%0d rep=%b, expected keys=%b lock=%b act=%0d rep=%b",
                  name, got[7:4], got[3], got[2:1], got[0], exp[7:4], exp[3], exp[2:1], exp[0]);
      end
   endtask

   task automatic step(input logic [4:0] raw, input string name, input logic [7:0] exp);
      drive(raw);
      @(posedge OutClock);
      @(negedge OutClock);
      check(name, exp);
   endtask

   initial begin
      // Single tap of Up. It is held 4 cycles, which is shorter than the repeat delay, so there is no repeat pulse.
      add(4, 5'b01011, 4'b1111, 1'b0, 2'd0, 1'b0);
      add(1, 5'b01111, 4'b1111, 1'b0, 2'd0, 1'b0);
      add(1, 5'b01111, 4'b1011, 1'b0, 2'd2, 1'b1);
      add(3, 5'b01111, 4'b1111, 1'b0, 2'd2, 1'b1);
      add(2, 5'b01111, 4'b1111, 1'b0, 2'd2, 1'b0);
      // Bounce on Left: the key is low for one sample at a time, so nothing changes.
      add(1, 5'b01110, 4'b1111, 1'b0, 2'd2, 1'b0);
      add(1, 5'b01111, 4'b1111, 1'b0, 2'd2, 1'b0);
      add(1, 5'b01110, 4'b1111, 1'b0, 2'd2, 1'b0);
      add(5, 5'b01111, 4'b1111, 1'b0, 2'd2, 1'b0);
      // Right held for 20 cycles: pulses in rows 5, 10, 12, ... 24.
      add(5, 5'b01101, 4'b1111, 1'b0, 2'd2, 1'b0);
      add(1, 5'b01101, 4'b1101, 1'b0, 2'd1, 1'b1);
      add(4, 5'b01101, 4'b1111, 1'b0, 2'd1, 1'b1);
      for (int p = 0; p < 5; p++) begin
         add(1, 5'b01101, 4'b1101, 1'b0, 2'd1, 1'b1);
         add(1, 5'b01101, 4'b1111, 1'b0, 2'd1, 1'b1);
      end
      add(1, 5'b01111, 4'b1101, 1'b0, 2'd1, 1'b1);
      add(1, 5'b01111, 4'b1111, 1'b0, 2'd1, 1'b1);
      add(1, 5'b01111, 4'b1101, 1'b0, 2'd1, 1'b1);
      add(1, 5'b01111, 4'b1111, 1'b0, 2'd1, 1'b1);
      add(1, 5'b01111, 4'b1101, 1'b0, 2'd1, 1'b1);
      add(2, 5'b01111, 4'b1111, 1'b0, 2'd1, 1'b0);
      // Up and Left pressed together: Left wins. After Left is released there is one IDLE cycle, then Up pulses.
      add(4, 5'b01010, 4'b1111, 1'b0, 2'd1, 1'b0);
      add(1, 5'b01011, 4'b1111, 1'b0, 2'd1, 1'b0);
      add(1, 5'b01011, 4'b1110, 1'b0, 2'd0, 1'b1);
      add(3, 5'b01011, 4'b1111, 1'b0, 2'd0, 1'b1);
      add(1, 5'b01011, 4'b1111, 1'b0, 2'd0, 1'b0);
      add(1, 5'b01111, 4'b1011, 1'b0, 2'd2, 1'b1);
      add(4, 5'b01111, 4'b1111, 1'b0, 2'd2, 1'b1);
      add(2, 5'b01111, 4'b1111, 1'b0, 2'd2, 1'b0);
      // Lock switch with a one-cycle glitch. It never produces a key pulse.
      add(1, 5'b11111, 4'b1111, 1'b0, 2'd2, 1'b0);
      add(1, 5'b01111, 4'b1111, 1'b0, 2'd2, 1'b0);
      add(5, 5'b11111, 4'b1111, 1'b0, 2'd2, 1'b0);
      add(2, 5'b11111, 4'b1111, 1'b1, 2'd2, 1'b0);
      add(5, 5'b01111, 4'b1111, 1'b1, 2'd2, 1'b0);
      add(1, 5'b01111, 4'b1111, 1'b0, 2'd2, 1'b0);

      drive(5'b01111);
      resetApp = 1'b1;
      repeat (3) @(posedge OutClock);
      @(negedge OutClock);
      check("reset_values", {4'b1111, 1'b0, 2'd0, 1'b0});
      resetApp = 1'b0;

      foreach (tbl[i]) begin
         for (int unsigned j = 0; j < tbl[i].n; j++) begin
            step(tbl[i].raw, $sformatf("vec%0d.%0d", i, j),
                 {tbl[i].keys, tbl[i].lock, tbl[i].act, tbl[i].rep});
         end
      end

      // Reset while Down is repeating. The outputs clear at once, and the still-held key starts again from scratch.
      for (int r = 0; r < 5; r++) step(5'b00111, "down_wait", {4'b1111, 1'b0, 2'd2, 1'b0});
      step(5'b00111, "down_first", {4'b0111, 1'b0, 2'd3, 1'b1});
      for (int r = 0; r < 4; r++) step(5'b00111, "down_hold", {4'b1111, 1'b0, 2'd3, 1'b1});
      step(5'b00111, "down_rpt1", {4'b0111, 1'b0, 2'd3, 1'b1});
      step(5'b00111, "down_gap", {4'b1111, 1'b0, 2'd3, 1'b1});
      step(5'b00111, "down_rpt2", {4'b0111, 1'b0, 2'd3, 1'b1});
      #2 resetApp = 1'b1;
      #1 check("reset_async", {4'b1111, 1'b0, 2'd0, 1'b0});
      @(posedge OutClock);
      @(negedge OutClock);
      check("reset_held", {4'b1111, 1'b0, 2'd0, 1'b0});
      resetApp = 1'b0;
      for (int r = 0; r < 5; r++) step(5'b00111, "post_rst_wait", {4'b1111, 1'b0, 2'd0, 1'b0});
      step(5'b00111, "post_rst_first", {4'b0111, 1'b0, 2'd3, 1'b1});
      step(5'b00111, "post_rst_hold", {4'b1111, 1'b0, 2'd3, 1'b1});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
